// File: rtl/iob_ssd_scan_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller:
// FSM encoding, digit count, hex segment table and idle drive levels.
package iob_ssd_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } ssd_state_t;

    localparam int N_DIGITS = 4;

    localparam logic [7:0] CATHODE_OFF = 8'hFF;
    localparam logic [3:0] ANODE_OFF   = 4'hF;

    // Active-low {g,f,e,d,c,b,a} pattern for each hex nibble, index 0 first.
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/iob_ssd_hex2seg.sv
// Combinational nibble + decimal point to active-low cathode decoder.
// Output layout is {dp,g,f,e,d,c,b,a}.
module iob_ssd_hex2seg
    import iob_ssd_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] cathode
);

    // Table lookup for segments; the decimal point is lit when dp is 1.
    always_comb begin
        cathode = {~dp, SEG_TABLE[nibble]};
    end

endmodule

// File: rtl/iob_ssd_scan.sv
// Autonomous scan controller for a 4-digit multiplexed seven-segment display.
// Each digit slot lasts REFRESH_DIV cycles: GHOST_CYC cycles of anode-off
// blanking (cathodes already show the new digit) followed by the drive phase.
// Data and decimal points are snapshotted at frame start so a frame never
// mixes old and new values. All outputs are registered.
// Optional feature macro: IOB_SSD_SCAN_LZB_EN enables leading-zero blanking.
module iob_ssd_scan
    import iob_ssd_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GHOST_CYC   = 16
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        en_i,
    input  logic [15:0] data_i,
    input  logic [3:0]  dp_i,
    output logic [7:0]  cathode_o,
    output logic [3:0]  anode_o,
    output logic [1:0]  digit_sel_o,
    output logic        frame_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((GHOST_CYC > 0) ? GHOST_CYC - 1 : 0);
    // With no blanking configured, every slot starts directly in DRIVE.
    localparam ssd_state_t SLOT_START = (GHOST_CYC == 0) ? ST_DRIVE : ST_BLANK;

    ssd_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       digit, digit_nxt;
    logic [15:0]      shadow_data, shadow_data_nxt;
    logic [3:0]       shadow_dp, shadow_dp_nxt;
    logic             frame_nxt;

    logic [3:0]       nibble_nxt;
    logic             dp_nxt;
    logic [7:0]       seg_nxt;
    logic             suppress_nxt;
    logic [7:0]       cathode_nxt;
    logic [3:0]       anode_nxt;
    logic [1:0]       sel_nxt;

    // State, prescaler, digit counter and shadow registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            digit       <= 2'd0;
            shadow_data <= 16'h0000;
            shadow_dp   <= 4'h0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            digit       <= digit_nxt;
            shadow_data <= shadow_data_nxt;
            shadow_dp   <= shadow_dp_nxt;
        end
    end

    // Next-state logic: slot sequencing, digit advance and frame snapshot.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        digit_nxt       = digit;
        shadow_data_nxt = shadow_data;
        shadow_dp_nxt   = shadow_dp;
        frame_nxt       = 1'b0;
        if (!en_i) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            digit_nxt = 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt       = SLOT_START;
                    cnt_nxt         = '0;
                    digit_nxt       = 2'd0;
                    shadow_data_nxt = data_i;
                    shadow_dp_nxt   = dp_i;
                end
                ST_BLANK: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == BLANK_LAST) state_nxt = ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_nxt   = '0;
                        digit_nxt = digit + 2'd1;
                        state_nxt = SLOT_START;
                        if (digit == 2'(N_DIGITS - 1)) begin
                            shadow_data_nxt = data_i;
                            shadow_dp_nxt   = dp_i;
                            frame_nxt       = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pick the nibble/dp the next cycle will display.
    always_comb begin
        nibble_nxt = shadow_data_nxt[{digit_nxt, 2'b00} +: 4];
        dp_nxt     = shadow_dp_nxt[digit_nxt];
    end

    iob_ssd_hex2seg u_hex2seg (
        .nibble  (nibble_nxt),
        .dp      (dp_nxt),
        .cathode (seg_nxt)
    );

`ifdef IOB_SSD_SCAN_LZB_EN
    // A digit is dark when it and every more significant nibble are zero.
    always_comb begin
        case (digit_nxt)
            2'd3:    suppress_nxt = (shadow_data_nxt[15:12] == 4'h0);
            2'd2:    suppress_nxt = (shadow_data_nxt[15:8]  == 8'h00);
            2'd1:    suppress_nxt = (shadow_data_nxt[15:4]  == 12'h000);
            default: suppress_nxt = 1'b0;
        endcase
    end
`else
    // Every digit is always driven.
    always_comb begin
        suppress_nxt = 1'b0;
    end
`endif

    // Output values that take effect on the same edge as the state change.
    always_comb begin
        cathode_nxt = CATHODE_OFF;
        anode_nxt   = ANODE_OFF;
        sel_nxt     = 2'd0;
        if (state_nxt != ST_IDLE) begin
            sel_nxt = digit_nxt;
            if (!suppress_nxt) begin
                cathode_nxt = seg_nxt;
                if (state_nxt == ST_DRIVE) anode_nxt = ~(4'b0001 << digit_nxt);
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cathode_o   <= CATHODE_OFF;
            anode_o     <= ANODE_OFF;
            digit_sel_o <= 2'd0;
            frame_o     <= 1'b0;
        end else begin
            cathode_o   <= cathode_nxt;
            anode_o     <= anode_nxt;
            digit_sel_o <= sel_nxt;
            frame_o     <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_iob_ssd_scan.sv
// Directed bench for iob_ssd_scan with REFRESH_DIV=8, GHOST_CYC=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_iob_ssd_scan;

`ifdef IOB_SSD_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        arst_n;
    logic        en_i;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic [7:0]  cathode_o;
    logic [3:0]  anode_o;
    logic [1:0]  digit_sel_o;
    logic        frame_o;

    int checks   = 0;
    int failures = 0;

    iob_ssd_scan #(.REFRESH_DIV(8), .GHOST_CYC(2)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .en_i        (en_i),
        .data_i      (data_i),
        .dp_i        (dp_i),
        .cathode_o   (cathode_o),
        .anode_o     (anode_o),
        .digit_sel_o (digit_sel_o),
        .frame_o     (frame_o)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " anode"},   {4'h0, anode_o},     8'h0F);
        chk({tag, " cathode"}, cathode_o,           8'hFF);
        chk({tag, " sel"},     {6'h0, digit_sel_o}, 8'h00);
        chk({tag, " frame"},   {7'h0, frame_o},     8'h00);
    endtask

    // One 8-cycle digit slot: 2 blank cycles then 6 drive cycles.
    task automatic run_slot(input int dig, input logic [7:0] ecath, input logic fpulse,
                            input logic sup, input int chg_at, input logic [15:0] chg_data);
        logic [3:0] ea;
        for (int i = 0; i < 8; i++) begin
            tick();
            ea = 4'hF;
            if (i >= 2 && !sup) ea[dig] = 1'b0;
            chk($sformatf("anode d%0d c%0d", dig, i),   {4'h0, anode_o},     {4'h0, ea});
            chk($sformatf("cathode d%0d c%0d", dig, i), cathode_o,           ecath);
            chk($sformatf("sel d%0d c%0d", dig, i),     {6'h0, digit_sel_o}, 8'(dig));
            chk($sformatf("frame d%0d c%0d", dig, i),   {7'h0, frame_o},     {7'h0, (i == 0) && fpulse});
            if (i == chg_at) data_i = chg_data;
        end
    endtask

    initial begin
        arst_n = 1'b0;
        en_i   = 1'b0;
        data_i = 16'h0000;
        dp_i   = 4'h0;
        tick();
        tick();
        chk_idle("reset");
        arst_n = 1'b1;
        tick();
        chk_idle("idle_no_en");

        // Basic scan of 1230.
        data_i = 16'h1230;
        en_i   = 1'b1;
        run_slot(0, 8'hC0, 1'b0, 1'b0, -1, 16'h0);
        run_slot(1, 8'hB0, 1'b0, 1'b0, -1, 16'h0);
        run_slot(2, 8'hA4, 1'b0, 1'b0, -1, 16'h0);
        run_slot(3, 8'hF9, 1'b0, 1'b0, -1, 16'h0);

        // Mid-frame data change stays hidden until the next frame.
        run_slot(0, 8'hC0, 1'b1, 1'b0, -1, 16'h0);
        run_slot(1, 8'hB0, 1'b0, 1'b0, 3, 16'h8888);
        run_slot(2, 8'hA4, 1'b0, 1'b0, -1, 16'h0);
        run_slot(3, 8'hF9, 1'b0, 1'b0, -1, 16'h0);

        // New data shows; decimal point change made mid-frame.
        run_slot(0, 8'h80, 1'b1, 1'b0, -1, 16'h0);
        dp_i = 4'b0100;
        run_slot(1, 8'h80, 1'b0, 1'b0, -1, 16'h0);
        run_slot(2, 8'h80, 1'b0, 1'b0, -1, 16'h0);
        run_slot(3, 8'h80, 1'b0, 1'b0, -1, 16'h0);

        // Decimal point on digit 2 only.
        run_slot(0, 8'h80, 1'b1, 1'b0, -1, 16'h0);
        run_slot(1, 8'h80, 1'b0, 1'b0, -1, 16'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("dp2 cathode c%0d", i), cathode_o, 8'h00);
        end
        chk("dp2 anode drive4", {4'h0, anode_o}, 8'h0B);

        // Disable on the 4th drive cycle of digit 2.
        en_i = 1'b0;
        tick();
        chk_idle("disable");
        tick();
        chk_idle("disable_hold");

        // Re-enable with leading zeros.
        data_i = 16'h0050;
        dp_i   = 4'h0;
        en_i   = 1'b1;
        run_slot(0, 8'hC0, 1'b0, 1'b0, -1, 16'h0);
        run_slot(1, 8'h92, 1'b0, 1'b0, -1, 16'h0);
        run_slot(2, LZB ? 8'hFF : 8'hC0, 1'b0, LZB, -1, 16'h0);
        run_slot(3, LZB ? 8'hFF : 8'hC0, 1'b0, LZB, -1, 16'h0);
        run_slot(0, 8'hC0, 1'b1, 1'b0, -1, 16'h0);

        // Asynchronous reset mid-drive of digit 1.
        for (int i = 0; i < 4; i++) tick();
        chk("pre_reset anode", {4'h0, anode_o}, 8'h0D);
        #2;
        arst_n = 1'b0;
        #1;
        chk_idle("async_reset");
        tick();
        tick();
        tick();
        chk_idle("reset_hold");
        arst_n = 1'b1;
        tick();
        chk("restart anode",   {4'h0, anode_o},     8'h0F);
        chk("restart cathode", cathode_o,           8'hC0);
        chk("restart sel",     {6'h0, digit_sel_o}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
